// File: rtl/pulse_generator_if.sv
// Control/data bundle between the pulse sequencer and the I/Q pulse generator.
//   start, mod_freq, pulse_length, amplitude, phase_offset : request + parameters
//   data_i_out/data_q_out : 5 lanes of 16-bit signed I/Q, lane 0 earliest in time
//   data_valid, busy, done : output qualifier and status
// master = sequencer side, slave = pulse generator side.
interface pulse_generator_if;
  logic                    start;
  logic [3:0]              mod_freq;
  logic [10:0]             pulse_length;
  logic signed [15:0]      amplitude;
  logic [6:0]              phase_offset;
  logic [4:0][15:0]        data_i_out;
  logic [4:0][15:0]        data_q_out;
  logic                    data_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output start, mod_freq, pulse_length, amplitude, phase_offset,
    input  data_i_out, data_q_out, data_valid, busy, done
  );

  modport slave (
    input  start, mod_freq, pulse_length, amplitude, phase_offset,
    output data_i_out, data_q_out, data_valid, busy, done
  );
endinterface

// File: rtl/pulse_generator.sv
// Rectangular-envelope I/Q pulse synthesiser for a 500 MSPS DAC (5 samples per clk100 cycle).
// Ports:
//   clk100 : 100 MHz system clock
//   reset  : asynchronous active-low reset; aborts any pulse in flight without a done strobe
//   pg     : pulse_generator_if.slave (request/parameters in, I/Q lanes and status out)
// A request latches all parameters, issues one 5-lane phase vector per cycle for pulse_length
// cycles, and pushes it through a 3-stage pipeline (phase -> cos/sin LUT -> multiply).
module pulse_generator (
  input  logic             clk100,
  input  logic             reset,
  pulse_generator_if.slave pg
);

  localparam int unsigned Lanes      = 5;
  localparam int unsigned PhaseSteps = 100;
  localparam logic [7:0]  Steps8     = 8'(PhaseSteps);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  // Quarter-wave cosine, round(32767*cos(2*pi*k/100)) for k = 0..25.
  function automatic logic signed [15:0] quarter_cos(input logic [6:0] idx);
    logic signed [15:0] v;
    case (idx)
      7'd0:    v = 16'sd32767;
      7'd1:    v = 16'sd32702;
      7'd2:    v = 16'sd32509;
      7'd3:    v = 16'sd32187;
      7'd4:    v = 16'sd31738;
      7'd5:    v = 16'sd31163;
      7'd6:    v = 16'sd30466;
      7'd7:    v = 16'sd29648;
      7'd8:    v = 16'sd28714;
      7'd9:    v = 16'sd27666;
      7'd10:   v = 16'sd26509;
      7'd11:   v = 16'sd25247;
      7'd12:   v = 16'sd23886;
      7'd13:   v = 16'sd22431;
      7'd14:   v = 16'sd20886;
      7'd15:   v = 16'sd19260;
      7'd16:   v = 16'sd17557;
      7'd17:   v = 16'sd15786;
      7'd18:   v = 16'sd13952;
      7'd19:   v = 16'sd12062;
      7'd20:   v = 16'sd10126;
      7'd21:   v = 16'sd8149;
      7'd22:   v = 16'sd6140;
      7'd23:   v = 16'sd4107;
      7'd24:   v = 16'sd2057;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  // Full-cycle cosine from the quarter table by symmetry; 25 and 75 land on exact zero.
  function automatic logic signed [15:0] cos_lut(input logic [6:0] k);
    logic signed [15:0] v;
    if (k <= 7'd25) begin
      v = quarter_cos(k);
    end else if (k <= 7'd50) begin
      v = -quarter_cos(7'd50 - k);
    end else if (k <= 7'd75) begin
      v = -quarter_cos(k - 7'd50);
    end else begin
      v = quarter_cos(7'd100 - k);
    end
    return v;
  endfunction

  // sin(k) = cos((k + 75) mod 100)
  function automatic logic [6:0] sin_index(input logic [6:0] k);
    return (k < 7'd25) ? k + 7'd75 : k - 7'd25;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Control FSM and latched parameters
  // ---------------------------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [3:0]         freq_q, freq_d;
  logic [10:0]        len_q, len_d;      // issue cycles still to go in RUN
  logic signed [15:0] amp_q, amp_d;
  logic [6:0]         base_q, base_d;    // phase of lane 0 in the current issue cycle
  logic               flush_q, flush_d;  // second FLUSH cycle marker
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               issue;

  logic [6:0]         off_red;
  logic [7:0]         step_raw;
  logic [7:0]         step;
  logic [7:0]         base_sum;
  logic [6:0]         base_next;

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      freq_q  <= '0;
      len_q   <= '0;
      amp_q   <= '0;
      base_q  <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      len_q   <= len_d;
      amp_q   <= amp_d;
      base_q  <= base_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    off_red   = (pg.phase_offset >= 7'(PhaseSteps)) ? pg.phase_offset - 7'(PhaseSteps)
                                                    : pg.phase_offset;
    // Per-cycle advance of lane 0: 10*mod_freq reduced mod 100 (at most 150 before reduction).
    step_raw  = 8'({freq_q, 3'b000}) + 8'({freq_q, 1'b0});
    step      = (step_raw >= Steps8) ? step_raw - Steps8 : step_raw;
    base_sum  = 8'(base_q) + step;
    base_next = 7'((base_sum >= Steps8) ? base_sum - Steps8 : base_sum);

    state_d = state_q;
    freq_d  = freq_q;
    len_d   = len_q;
    amp_d   = amp_q;
    base_d  = base_q;
    flush_d = flush_q;

    unique case (state_q)
      StIdle: begin
        if (pg.start) begin
          freq_d  = pg.mod_freq;
          len_d   = pg.pulse_length;
          amp_d   = pg.amplitude;
          base_d  = off_red;
          state_d = (pg.pulse_length == 11'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        base_d = base_next;
        len_d  = len_q - 11'd1;
        if (len_q == 11'd1) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end
      end
      StFlush: begin
        // Two cycles here line DONE up with the cycle after the last valid output.
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // busy/done are registered, so both lag the state by one cycle: busy starts the cycle after
  // the start edge and the done strobe coincides with the first IDLE cycle.
  always_comb begin
    issue  = (state_q == StRun);
    busy_d = (state_q != StIdle);
    done_d = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: per-lane phase index
  // ---------------------------------------------------------------------------------------------
  logic [7:0] lane_sum [Lanes];
  logic [6:0] phase_d  [Lanes];
  logic [6:0] phase_q  [Lanes];
  logic       v1_q;

  always_comb begin
    for (int j = 0; j < Lanes; j++) begin
      // base < 100 and 2*mod_freq*j <= 120, so at most two wraps are needed.
      lane_sum[j] = 8'(base_q) + 8'(freq_q) * 8'(2 * j);
      if (lane_sum[j] >= 2 * Steps8) begin
        phase_d[j] = 7'(lane_sum[j] - 2 * Steps8);
      end else if (lane_sum[j] >= Steps8) begin
        phase_d[j] = 7'(lane_sum[j] - Steps8);
      end else begin
        phase_d[j] = 7'(lane_sum[j]);
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      for (int j = 0; j < Lanes; j++) begin
        phase_q[j] <= '0;
      end
    end else begin
      v1_q <= issue;
      for (int j = 0; j < Lanes; j++) begin
        phase_q[j] <= phase_d[j];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: cos/sin lookup
  // ---------------------------------------------------------------------------------------------
  logic signed [15:0] cos_d [Lanes];
  logic signed [15:0] sin_d [Lanes];
  logic signed [15:0] cos_q [Lanes];
  logic signed [15:0] sin_q [Lanes];
  logic               v2_q;

  always_comb begin
    for (int j = 0; j < Lanes; j++) begin
      cos_d[j] = cos_lut(phase_q[j]);
      sin_d[j] = cos_lut(sin_index(phase_q[j]));
    end
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      v2_q <= 1'b0;
      for (int j = 0; j < Lanes; j++) begin
        cos_q[j] <= '0;
        sin_q[j] <= '0;
      end
    end else begin
      v2_q <= v1_q;
      for (int j = 0; j < Lanes; j++) begin
        cos_q[j] <= cos_d[j];
        sin_q[j] <= sin_d[j];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 3: amplitude multiply, floor-shift by 15; lanes forced to zero when not valid
  // ---------------------------------------------------------------------------------------------
  logic signed [31:0]     prod_i [Lanes];
  logic signed [31:0]     prod_q [Lanes];
  logic [Lanes-1:0][15:0] i_d, i_q;
  logic [Lanes-1:0][15:0] q_d, q_q;
  logic                   valid_q;

  always_comb begin
    for (int j = 0; j < Lanes; j++) begin
      prod_i[j] = amp_q * cos_q[j];
      prod_q[j] = amp_q * sin_q[j];
      i_d[j]    = v2_q ? 16'(prod_i[j] >>> 15) : 16'd0;
      q_d[j]    = v2_q ? 16'(prod_q[j] >>> 15) : 16'd0;
    end
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= v2_q;
      i_q     <= i_d;
      q_q     <= q_d;
    end
  end

  assign pg.data_i_out = i_q;
  assign pg.data_q_out = q_q;
  assign pg.data_valid = valid_q;
  assign pg.busy       = busy_q;
  assign pg.done       = done_q;

endmodule
